// File: rtl/rasgen_multi_if.sv
// rasgen_multi_if: request/response bundle for the multi-bank RAS generator.
//   on/bs      - open strobe and its bank select
//   off/offbs  - close strobe and its bank select
//   allon      - broadcast open to every bank
//   alloff     - broadcast close to every bank
//   csl        - active-low chip select per bank
//   ready      - per-bank "idle, may be opened"
//   err        - one-cycle pulse on an open aimed at a busy bank
// master drives requests and observes outputs; slave is the generator.
interface rasgen_multi_if #(
    parameter int NBANKS = 4
);
    logic              on;
    logic [NBANKS-1:0] bs;
    logic              off;
    logic [NBANKS-1:0] offbs;
    logic              allon;
    logic              alloff;
    logic [NBANKS-1:0] csl;
    logic [NBANKS-1:0] ready;
    logic              err;

    modport master (
        output on, bs, off, offbs, allon, alloff,
        input  csl, ready, err
    );

    modport slave (
        input  on, bs, off, offbs, allon, alloff,
        output csl, ready, err
    );
endinterface

// File: rtl/rasgen_multi.sv
// rasgen_multi: per-bank RAS / chip-select generator with minimum active
// time, precharge lockout, deferred close and a misuse error pulse.
//   clk  - system clock, all state changes on the rising edge
//   res  - synchronous active-high reset
//   bus  - rasgen_multi_if.slave (requests in; csl, ready, err out)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | bank closed, ready=1, csl=1; accepts an open
// ACTIVE | bank open, csl=0; cnt counts down the minimum active time,
//        | pend remembers a close that arrived before cnt reached 0
// PRECH  | bank closing, ready=0; cnt counts down the precharge lockout
module rasgen_multi #(
    parameter int NBANKS = 4,
    parameter int TRAS   = 5,
    parameter int TRP    = 3,
    parameter int CNTW   = 4
) (
    input  logic           clk,
    input  logic           res,
    rasgen_multi_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_PRECH  = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] TRAS_LD = CNTW'(TRAS - 1);
    localparam logic [CNTW-1:0] TRP_LD  = CNTW'(TRP - 1);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    state_t            state_q [NBANKS];
    state_t            state_d [NBANKS];
    logic [CNTW-1:0]   cnt_q   [NBANKS];
    logic [CNTW-1:0]   cnt_d   [NBANKS];
    logic [NBANKS-1:0] pend_q, pend_d;
    logic              err_q, err_d;

    logic [NBANKS-1:0] open_v, close_v;
    logic [NBANKS-1:0] csl_v, ready_v;

    assign open_v  = ({NBANKS{bus.on}}  & bus.bs)    | {NBANKS{bus.allon}};
    assign close_v = ({NBANKS{bus.off}} & bus.offbs) | {NBANKS{bus.alloff}};

    always_comb begin
        err_d  = 1'b0;
        pend_d = pend_q;
        for (int i = 0; i < NBANKS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                S_IDLE: begin
                    // open wins over a coincident close on an idle bank
                    if (open_v[i]) begin
                        state_d[i] = S_ACTIVE;
                        cnt_d[i]   = TRAS_LD;
                        pend_d[i]  = 1'b0;
                    end
                end
                S_ACTIVE: begin
                    if (open_v[i]) begin
                        err_d = 1'b1;
                    end
                    if (close_v[i] || pend_q[i]) begin
                        if (cnt_q[i] == '0) begin
                            state_d[i] = S_PRECH;
                            cnt_d[i]   = TRP_LD;
                            pend_d[i]  = 1'b0;
                        end else begin
                            // tRAS not yet met: hold the close until cnt hits 0
                            pend_d[i]  = 1'b1;
                            cnt_d[i]   = cnt_q[i] - CNT_ONE;
                        end
                    end else if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
                end
                S_PRECH: begin
                    if (open_v[i]) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q[i] == '0) begin
                        state_d[i] = S_IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                    cnt_d[i]   = '0;
                    pend_d[i]  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < NBANKS; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NBANKS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    // outputs are pure decodes of registered state: no input-to-output path
    always_comb begin
        csl_v   = '1;
        ready_v = '1;
        for (int i = 0; i < NBANKS; i++) begin
            csl_v[i]   = (state_q[i] != S_ACTIVE);
            ready_v[i] = (state_q[i] == S_IDLE);
        end
    end

    assign bus.csl   = csl_v;
    assign bus.ready = ready_v;
    assign bus.err   = err_q;

endmodule

// File: doc/rasgen_multi.md
Name: rasgen_multi

Overview:
- Parametrised multi-bank RAS/chip-select generator; successor to the single-bank JK-style RAS generator in the memory controller.
- Holds one active-low chip select per DRAM bank, opened by bank-selected or broadcast "on" requests and closed by bank-selected or broadcast "off" requests.
- Adds what the single-bank block lacks: per-bank FSM, minimum active time (tRAS), precharge lockout (tRP), deferred close, and a misuse error pulse.

Parameters:
- NBANKS, 4, number of banks / chip selects (1..16)
- TRAS, 5, minimum clock cycles csl stays low once asserted (>=1)
- TRP, 3, clock cycles a bank stays in precharge after close before it can reopen (>=1)
- CNTW, 4, width of per-bank timing counter; must satisfy TRAS-1 and TRP-1 < 2^CNTW

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- res  in  1  reset, synchronous, active-high
- on  in  1  open strobe, applies to banks selected by bs
- bs  in  NBANKS  one-hot or multi-hot bank select for on
- off  in  1  close strobe, applies to banks selected by offbs
- offbs  in  NBANKS  bank select for off
- allon  in  1  broadcast open to every bank (refresh style)
- alloff  in  1  broadcast close to every bank
- csl  out  NBANKS  active-low chip select per bank, registered
- ready  out  NBANKS  1 = bank IDLE and may be opened, registered
- err  out  1  one-cycle pulse: an open request hit a non-IDLE bank

Behaviour:
- Reset: res sampled high at an edge puts all banks in IDLE; csl=all 1s; ready=all 1s; err=0; counters=0; pending-close flags=0. Reset mid-operation drops csl immediately (next edge), with no precharge and no tRAS honoured.
- Per-bank request decode: open_i = (on & bs[i]) | allon; close_i = (off & offbs[i]) | alloff.
- Per-bank states: IDLE, ACTIVE, PRECH. All outputs decode directly from registered state: csl[i]=0 iff ACTIVE; ready[i]=1 iff IDLE.
- IDLE: open_i -> ACTIVE, cnt<=TRAS-1, pend<=0. close_i is ignored, including when it coincides with open_i (open wins).
- ACTIVE: cnt decrements each edge while nonzero.
  - close_i or pend set, with sampled cnt==0 -> PRECH, cnt<=TRP-1, pend<=0.
  - close_i with cnt!=0 -> stay ACTIVE, pend<=1; the deferred close executes at the first edge where cnt==0.
  - Net result: csl low for at least TRAS cycles. A close arriving on the opening edge itself is not seen, because the bank was IDLE.
- PRECH: cnt decrements; at an edge with sampled cnt==0 -> IDLE. ready is low for exactly TRP cycles. close_i is ignored.
- Open to a non-IDLE bank (ACTIVE or PRECH) is ignored, and err pulses high the cycle after. allon counts as an error only for banks that are not IDLE and are selected. The per-bank err terms are ORed.
- open_i and close_i in the same cycle on an ACTIVE bank: close is processed as above and err pulses.
- Banks are fully independent; any mix of simultaneous opens and closes across banks is legal.
- No combinational path from inputs to outputs. Latency from request edge to csl/ready change is 1 clock.

Test Plan:
- Reset: res=1 for 2 cycles with random inputs -> csl=4'hF, ready=4'hF, err=0; then assert res while bank 2 is ACTIVE -> csl[2]=1 and ready[2]=1 after that edge.
- Basic open/close, TRAS=5, TRP=3: on with bs=4'b0001 at edge 0, off with offbs=4'b0001 at edge 10 -> csl[0] low after edges 0..9, high after edge 10; ready[0] low after edges 0..12, high after edge 13.
- Early close deferred: on bank 1 at edge 0, off bank 1 at edge 1 -> csl[1] low for exactly 5 cycles, rising after edge 5; ready[1] returns after edge 8.
- Broadcast: allon at edge 0 -> csl=4'h0 after edge 0; alloff at edge 6 -> csl=4'hF after edge 6; ready=4'hF after edge 9.
- Misuse: on bank 3 at edge 0, on bank 3 again at edge 2 -> err=1 only in the cycle after edge 2, no state change; on bank 3 during PRECH -> err pulse, bank reopens only after ready[3]=1.
- Simultaneous: on+off on IDLE bank 0 at the same edge -> bank opens and no close is pending; open bank 0 while closing bank 1 at the same edge -> both take effect independently.
